mem_unit: RTL and testbench

- Parametrised successor to the CPU's fixed 32-bit MAR/MDR register pair.
- Holds the memory address register (MAR) and memory data register (MDR), and drives a ready-handshaked memory port.
- Provides read/write sequencing, wait-state tolerance and a timeout error, which the current single-cycle mem_rd/mem_wr strobes lack.
- Sits between the control unit, the a/b/result buses and external memory.

---
 rtl/mem_unit_if.sv | 23 ++
 rtl/mem_unit.sv | 124 ++++++++++++
 tb/tb_mem_unit.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_unit_if.sv
// Memory-side port of mem_unit: request strobes, address/data out, read data and ready back.
// The master holds mem_rd/mem_wr plus stable address/data until mem_ready or abort.
interface mem_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rd;
  logic                  mem_wr;
  logic                  mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_unit.sv
// MAR/MDR pair with a ready-handshaked memory port; done/err pulse the cycle after ready/timeout (min 2 cycles from start).
// Wait states are absorbed up to TIMEOUT cycles; MEM_UNIT_POSTINC_EN adds optional MAR post-increment.
module mem_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15,
  parameter int CNT_WIDTH  = $clog2(TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  ld_mar,
  input  logic                  ld_mdr,
  input  logic                  oe_mar,
  input  logic                  oe_mdr,
  output tri   [DATA_WIDTH-1:0] a,
  output tri   [DATA_WIDTH-1:0] b,
  input  logic                  start_rd,
  input  logic                  start_wr,
`ifdef MEM_UNIT_POSTINC_EN
  input  logic                  postinc,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  mem_unit_if.master            mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  done_nxt, err_nxt;
  logic                  complete;
  logic [ADDR_WIDTH-1:0] mar;
  logic [DATA_WIDTH-1:0] mdr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    complete   = 1'b0;
    busy       = (state != IDLE);
    mem.mem_rd = (state == RD);
    mem.mem_wr = (state == WR);
    case (state)
      IDLE: begin
        if (start_rd) begin
          state_nxt = RD;
          cnt_nxt   = '0;
        end else if (start_wr) begin
          state_nxt = WR;
          cnt_nxt   = '0;
        end
      end
      RD, WR: begin
        // Ready on the last permitted wait cycle still completes normally.
        if (mem.mem_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          complete  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_WIDTH'(TIMEOUT - 1)) begin
            state_nxt = IDLE;
            err_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_UNIT_POSTINC_EN
  logic postinc_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mar <= '0;
      mdr <= '0;
`ifdef MEM_UNIT_POSTINC_EN
      postinc_q <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (ld_mar) mar <= in[ADDR_WIDTH-1:0];
      if (ld_mdr) mdr <= in;
`ifdef MEM_UNIT_POSTINC_EN
      if (start_rd || start_wr) postinc_q <= postinc;
`endif
    end else begin
      if (complete && state == RD) mdr <= mem.mem_rdata;
`ifdef MEM_UNIT_POSTINC_EN
      if (complete && postinc_q) mar <= mar + ADDR_WIDTH'(DATA_WIDTH / 8);
`endif
    end
  end

  assign mem.mem_addr  = mar;
  assign mem.mem_wdata = mdr;

  assign a = oe_mdr ? mdr : {DATA_WIDTH{1'bz}};
  assign b = oe_mar ? DATA_WIDTH'(mar) : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: directed reset/conflict sequences, a vector table and random transfers vs. a transfer-level model.
module tb_mem_unit;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst_n, ld_mar, ld_mdr, oe_mar, oe_mdr, start_rd, start_wr;
  logic [DW-1:0] in;
  wire  [DW-1:0] a, b;
  logic          busy, done, err;
`ifdef MEM_UNIT_POSTINC_EN
  logic          postinc;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  mem_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

  mem_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .ld_mar   (ld_mar),
    .ld_mdr   (ld_mdr),
    .oe_mar   (oe_mar),
    .oe_mdr   (oe_mdr),
    .a        (a),
    .b        (b),
    .start_rd (start_rd),
    .start_wr (start_wr),
`ifdef MEM_UNIT_POSTINC_EN
    .postinc  (postinc),
`endif
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (mif)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  // Transfer-level expectation: a request survives up to TO-1 wait cycles.
  typedef struct {
    bit          ok;
    int          cyc;
    logic [31:0] mdr;
    logic [31:0] mar;
  } exp_t;

  function automatic exp_t model(input bit is_wr, input int waits, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input bit pinc);
    exp_t e;
    e.ok  = (waits < TO);
    e.cyc = e.ok ? waits + 1 : TO;
    e.mdr = (!is_wr && e.ok) ? rdata : wdata;
    e.mar = (pinc && e.ok) ? addr + 32'd4 : addr;
    return e;
  endfunction

  // Load MAR, then load MDR in the same cycle as the start; memory asserts ready after `waits` cycles.
  task automatic run_xfer(input string tag, input bit is_wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata, input int waits,
                          input bit pinc, input exp_t e);
    int cyc = 0;
    bit fin = 0, got_done = 0, got_err = 0, stable = 1, pulse = 1;
    @(negedge clk);
    in = addr; ld_mar = 1'b1;
    @(negedge clk);
    ld_mar = 1'b0; in = wdata; ld_mdr = 1'b1;
    if (is_wr) start_wr = 1'b1; else start_rd = 1'b1;
`ifdef MEM_UNIT_POSTINC_EN
    postinc = pinc;
`endif
    @(negedge clk);
    ld_mdr = 1'b0; start_rd = 1'b0; start_wr = 1'b0; in = 32'h999;
    for (int i = 0; i < 40 && !fin; i++) begin
      ld_mar = 1'b0; ld_mdr = 1'b0;
      if (done || err) begin
        fin = 1; got_done = done; got_err = err;
      end else begin
        if (mif.mem_rd !== !is_wr || mif.mem_wr !== is_wr || busy !== 1'b1) stable = 0;
        if (mif.mem_addr !== addr || mif.mem_wdata !== wdata) stable = 0;
        cyc++;
        mif.mem_ready = (cyc == waits + 1);
        mif.mem_rdata = (cyc == waits + 1) ? rdata : $urandom;
        // Loads and restarts issued mid-transfer must be ignored.
        ld_mar   = (cyc == 2);
        ld_mdr   = (cyc == 3);
        start_wr = (cyc == 2);
        @(negedge clk);
        start_wr = 1'b0;
      end
    end
    mif.mem_ready = 1'b0;
    if (!fin) chk({tag, " bound"}, 0, 1);
    if (busy !== 1'b0 || mif.mem_rd !== 1'b0 || mif.mem_wr !== 1'b0) pulse = 0;
    @(negedge clk);
    if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) pulse = 0;
    chk({tag, " done"}, got_done, e.ok);
    chk({tag, " err"}, got_err, !e.ok);
    chk({tag, " cycles"}, cyc, e.cyc);
    chk({tag, " stable"}, stable, 1);
    chk({tag, " pulse"}, pulse, 1);
    oe_mdr = 1'b1; oe_mar = 1'b1;
    #1;
    chk({tag, " mdr"}, a, e.mdr);
    chk({tag, " mar"}, b, e.mar);
    oe_mdr = 1'b0; oe_mar = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    bit          exp_ok;
    int          exp_cyc;
    logic [31:0] exp_mdr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    exp_t e;
    vecs[0] = '{0, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 0,  1, 1,  32'hDEAD_BEEF};
    vecs[1] = '{1, 32'h0000_0040, 32'h1234_5678, 32'h0000_0000, 3,  1, 4,  32'h1234_5678};
    vecs[2] = '{0, 32'h0000_0200, 32'hA5A5_A5A5, 32'h1111_2222, 14, 1, 15, 32'h1111_2222};
    vecs[3] = '{0, 32'h0000_0300, 32'hCAFE_F00D, 32'h7777_7777, 15, 0, 15, 32'hCAFE_F00D};
    vecs[4] = '{1, 32'h0000_07FC, 32'h55AA_55AA, 32'h0000_0000, 20, 0, 15, 32'h55AA_55AA};
    vecs[5] = '{0, 32'hFFFF_FFFC, 32'h0000_0001, 32'h0BAD_C0DE, 1,  1, 2,  32'h0BAD_C0DE};

    rst_n = 1'b0; ld_mar = 0; ld_mdr = 0; oe_mar = 0; oe_mdr = 0;
    start_rd = 0; start_wr = 0; in = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
`ifdef MEM_UNIT_POSTINC_EN
    postinc = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    oe_mar = 1'b1; oe_mdr = 1'b1;
    #1;
    chk("reset a", a, 32'h0);
    chk("reset b", b, 32'h0);
    chk("reset busy", busy, 0);
    chk("reset rd/wr", {mif.mem_rd, mif.mem_wr}, 2'b00);
    chk("reset done/err", {done, err}, 2'b00);
    oe_mar = 1'b0; oe_mdr = 1'b0;

    // Ready while idle is ignored
    @(negedge clk);
    mif.mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle ready busy", busy, 0);
    chk("idle ready done", done, 0);
    mif.mem_ready = 1'b0;

    // Simultaneous starts pick read; then reset mid-read drops it
    in = 32'h1234; ld_mar = 1'b1;
    @(negedge clk);
    ld_mar = 1'b0; start_rd = 1'b1; start_wr = 1'b1;
    @(negedge clk);
    start_rd = 1'b0; start_wr = 1'b0;
    chk("both start rd/wr", {mif.mem_rd, mif.mem_wr}, 2'b10);
    chk("both start addr", mif.mem_addr, 32'h1234);
    rst_n = 1'b0; mif.mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; mif.mem_ready = 1'b0;
    chk("rst mid rd", {mif.mem_rd, busy, done, err}, 4'b0000);
    @(negedge clk);
    chk("rst no pulse", {done, err}, 2'b00);
    oe_mar = 1'b1;
    #1;
    chk("rst mar", b, 32'h0);
    oe_mar = 1'b0;

    foreach (vecs[i]) begin
      e.ok = vecs[i].exp_ok; e.cyc = vecs[i].exp_cyc;
      e.mdr = vecs[i].exp_mdr; e.mar = vecs[i].addr;
      run_xfer($sformatf("vec%0d", i), vecs[i].is_wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].rdata, vecs[i].waits, 1'b0, e);
    end

`ifdef MEM_UNIT_POSTINC_EN
    e = model(1'b0, 0, 32'hFFFF_FFFC, 32'h0, 32'h1357_9BDF, 1'b1);
    run_xfer("postinc wrap", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h1357_9BDF, 0, 1'b1, e);
    e = model(1'b0, 20, 32'h0000_0010, 32'h2468, 32'h0, 1'b1);
    run_xfer("postinc timeout", 1'b0, 32'h0000_0010, 32'h2468, 32'h0, 20, 1'b1, e);
`endif

    for (int n = 0; n < 25; n++) begin
      bit          r_wr, r_pinc;
      int          r_waits;
      logic [31:0] r_addr, r_wdata, r_rdata;
      r_wr    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_waits = $urandom_range(0, TO + 3);
      r_pinc  = 1'b0;
`ifdef MEM_UNIT_POSTINC_EN
      r_pinc  = 1'($urandom_range(0, 1));
`endif
      e = model(r_wr, r_waits, r_addr, r_wdata, r_rdata, r_pinc);
      run_xfer($sformatf("rnd%0d", n), r_wr, r_addr, r_wdata, r_rdata, r_waits, r_pinc, e);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
